// File: rtl/video_timing_meter.sv
// Measures the incoming video raster: line/frame totals and active extents, live position,
// peak active luma, lock state and PAL / scandoubled classification.
module video_timing_meter #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [7:0] video,
    output logic [9:0] h_total,
    output logic [9:0] h_active,
    output logic [9:0] v_total,
    output logic [9:0] v_active,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       locked,
    output logic       pal_detect,
    output logic       dbl_detect,
    output logic       frame_pulse,
    output logic [7:0] luma_max
);

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM,
        LOCKED
    } lock_state_t;

    lock_state_t state;
    logic        hsync_q;
    logic        vsync_q;
    logic        h_rise;
    logic        v_rise;
    logic [9:0]  h_act_cnt;
    logic [9:0]  v_act_cnt;
    logic [7:0]  run_max;
    logic [3:0]  match_cnt;
    logic [9:0]  ref_h;
    logic [9:0]  ref_v;

    logic [9:0]  hpos_nxt;
    logic [9:0]  h_total_nxt;
    logic [9:0]  vpos_inc;
    logic [9:0]  v_total_nxt;
    logic [9:0]  v_act_inc;
    logic [7:0]  sample;
    logic [7:0]  run_max_nxt;
    logic        totals_match;

    function automatic logic [9:0] sat_inc(input logic [9:0] x);
        return (x == CNT_MAX) ? x : x + 10'd1;
    endfunction

    assign h_rise = ce_pix & hsync & ~hsync_q;
    assign v_rise = ce_pix & vsync & ~vsync_q;

    // Next-state values are shared between the measurement registers and the lock
    // comparison, so the FSM judges the totals being captured on this very cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hpos_nxt     = h_rise ? 10'd0 : sat_inc(hpos);
        h_total_nxt  = h_rise ? sat_inc(hpos) : h_total;
        vpos_inc     = h_rise ? sat_inc(vpos) : vpos;
        v_total_nxt  = v_rise ? vpos_inc : v_total;
        v_act_inc    = (h_rise && !vblank) ? sat_inc(v_act_cnt) : v_act_cnt;
        sample       = (!hblank && !vblank) ? video : 8'd0;
        run_max_nxt  = (sample > run_max) ? sample : run_max;
        totals_match = (h_total_nxt == ref_h) && (v_total_nxt == ref_v);
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous reset
    // so every register clears immediately, independent of clk and ce_pix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            h_act_cnt   <= '0;
            v_act_cnt   <= '0;
            run_max     <= '0;
            luma_max    <= '0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= v_rise;
            if (ce_pix) begin
                hsync_q <= hsync;
                vsync_q <= vsync;
                hpos    <= hpos_nxt;

                // The pixel on the rise cycle is the first pixel of the new line.
                if (h_rise) begin
                    h_total   <= h_total_nxt;
                    h_active  <= h_act_cnt;
                    h_act_cnt <= hblank ? 10'd0 : 10'd1;
                end else if (!hblank) begin
                    h_act_cnt <= sat_inc(h_act_cnt);
                end

                // A coincident hsync rise closes the old frame; the new one starts at zero.
                if (v_rise) begin
                    v_total   <= v_total_nxt;
                    v_active  <= v_act_inc;
                    vpos      <= '0;
                    v_act_cnt <= '0;
                    luma_max  <= run_max;
                    run_max   <= sample;
                end else begin
                    vpos      <= vpos_inc;
                    v_act_cnt <= v_act_inc;
                    run_max   <= run_max_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
            ref_h     <= '0;
            ref_v     <= '0;
        end else if (ce_pix) begin
            case (state)
                SEARCH: begin
                    if (v_rise) begin
                        ref_h     <= h_total_nxt;
                        ref_v     <= v_total_nxt;
                        match_cnt <= 4'd1;
                        if (LOCK_N <= 4'd1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (v_rise) begin
                        if (totals_match) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            ref_h     <= h_total_nxt;
                            ref_v     <= v_total_nxt;
                            match_cnt <= 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    // A runaway line (no hsync) is as much a loss of timing as a bad frame.
                    if ((v_rise && !totals_match) || hpos_nxt == CNT_MAX) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign pal_detect = (v_total >= 10'd281 && v_total <= 10'd399) || (v_total >= 10'd580);
    assign dbl_detect = (v_total >= 10'd400);

endmodule

// File: tb/tb_video_timing_meter.sv
// Directed bench for video_timing_meter: synthetic rasters with hand-computed totals,
// lock behaviour, saturation, ce_pix gating and mid-line reset.
module tb_video_timing_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic [7:0] video;
    logic [9:0] h_total;
    logic [9:0] h_active;
    logic [9:0] v_total;
    logic [9:0] v_active;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       locked;
    logic       pal_detect;
    logic       dbl_detect;
    logic       frame_pulse;
    logic [7:0] luma_max;

    int errors = 0;
    int checks = 0;

    video_timing_meter #(.LOCK_FRAMES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .video       (video),
        .h_total     (h_total),
        .h_active    (h_active),
        .v_total     (v_total),
        .v_active    (v_active),
        .hpos        (hpos),
        .vpos        (vpos),
        .locked      (locked),
        .pal_detect  (pal_detect),
        .dbl_detect  (dbl_detect),
        .frame_pulse (frame_pulse),
        .luma_max    (luma_max)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " h_total"},     32'(h_total),     0);
        check({tag, " h_active"},    32'(h_active),    0);
        check({tag, " v_total"},     32'(v_total),     0);
        check({tag, " v_active"},    32'(v_active),    0);
        check({tag, " hpos"},        32'(hpos),        0);
        check({tag, " vpos"},        32'(vpos),        0);
        check({tag, " locked"},      32'(locked),      0);
        check({tag, " pal"},         32'(pal_detect),  0);
        check({tag, " dbl"},         32'(dbl_detect),  0);
        check({tag, " frame_pulse"}, 32'(frame_pulse), 0);
        check({tag, " luma_max"},    32'(luma_max),    0);
    endtask

    // One ce_pix clock with the given inputs; outputs are read 1 time unit after the edge.
    task automatic pix(input logic h, input logic v, input logic hb, input logic vb,
                       input logic [7:0] vid);
        hsync  = h;
        vsync  = v;
        hblank = hb;
        vblank = vb;
        video  = vid;
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        ce_pix = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Frame-start pixel: coincident hsync and vsync rise, inside vertical blanking.
    task automatic kick();
        pix(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
    endtask

    task automatic run_line(input int hlen, input int hact, input logic vs, input logic vb,
                            input int div, input bit peak, input bit skip);
        for (int p = (skip ? 1 : 0); p < hlen; p++) begin
            logic       hb;
            logic [7:0] vid;
            hb  = (p >= hact);
            vid = hb ? 8'hFF : ((peak && p == hact / 2) ? 8'hC8 : 8'(16 + p));
            pix(p < 2, vs, hb, vb, vid);
            if (div == 2) gap();
        end
    endtask

    task automatic frame(input int lines, input int hlen, input int hact, input int vbl,
                         input int div, input bit skip);
        for (int l = 0; l < lines; l++)
            run_line(hlen, hact, l < 3, l < vbl, div, l == lines / 2, skip && l == 0);
    endtask

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        hblank = 1'b0;
        vblank = 1'b0;
        video  = 8'h00;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Line measurement: 638 pixels, 512 active, ce_pix every other clk.
        run_line(638, 512, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        pix(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        check("h_total 638", 32'(h_total), 638);
        check("h_active 512", 32'(h_active), 512);
        check("hpos after hrise", 32'(hpos), 0);
        check("vpos two lines", 32'(vpos), 2);

        // A sync edge while ce_pix=0 must wait for the next enabled sample.
        idle();
        ce_pix = 1'b0;
        hsync  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("gated hpos hold", 32'(hpos), 1);
        check("gated h_total hold", 32'(h_total), 638);
        pix(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("gated hpos load", 32'(hpos), 0);
        check("gated h_total", 32'(h_total), 2);

        // NTSC-like 262 lines, 22 blanked, ce_pix every other clk.
        idle();
        frame(262, 16, 12, 22, 2, 1'b0);
        frame(262, 16, 12, 22, 2, 1'b0);
        kick();
        check("ntsc frame_pulse", 32'(frame_pulse), 1);
        check("ntsc v_total", 32'(v_total), 262);
        check("ntsc v_active", 32'(v_active), 240);
        check("ntsc h_total", 32'(h_total), 16);
        check("ntsc h_active", 32'(h_active), 12);
        check("ntsc luma_max", 32'(luma_max), 32'hC8);
        check("ntsc pal", 32'(pal_detect), 0);
        check("ntsc dbl", 32'(dbl_detect), 0);
        check("ntsc locked", 32'(locked), 1);
        check("ntsc vpos", 32'(vpos), 0);
        gap();
        check("frame_pulse width", 32'(frame_pulse), 0);

        // Lock loss on a single 263-line frame, relock after two matching frames.
        frame(262, 16, 12, 22, 1, 1'b1);
        kick();
        check("stay locked", 32'(locked), 1);
        frame(263, 16, 12, 22, 1, 1'b1);
        kick();
        check("long frame v_total", 32'(v_total), 263);
        check("long frame unlock", 32'(locked), 0);
        frame(262, 16, 12, 22, 1, 1'b1);
        kick();
        check("confirm not locked", 32'(locked), 0);
        frame(262, 16, 12, 22, 1, 1'b1);
        kick();
        check("relocked", 32'(locked), 1);
        check("relocked v_total", 32'(v_total), 262);

        // Fresh start on a scandoubled PAL raster, ce_pix always on.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        frame(624, 16, 12, 48, 1, 1'b0);
        kick();
        check("pal second vrise locked", 32'(locked), 0);
        check("pal v_total first", 32'(v_total), 624);
        frame(624, 16, 12, 48, 1, 1'b1);
        kick();
        check("pal third vrise locked", 32'(locked), 1);
        check("pal v_total", 32'(v_total), 624);
        check("pal v_active", 32'(v_active), 576);
        check("pal pal_detect", 32'(pal_detect), 1);
        check("pal dbl_detect", 32'(dbl_detect), 1);

        // Classification boundaries.
        frame(281, 4, 3, 22, 1, 1'b1);
        kick();
        check("281 v_total", 32'(v_total), 281);
        check("281 v_active", 32'(v_active), 259);
        check("281 pal", 32'(pal_detect), 1);
        check("281 dbl", 32'(dbl_detect), 0);
        check("281 unlock", 32'(locked), 0);
        frame(399, 4, 3, 22, 1, 1'b1);
        kick();
        check("399 pal", 32'(pal_detect), 1);
        check("399 dbl", 32'(dbl_detect), 0);
        frame(400, 4, 3, 22, 1, 1'b1);
        kick();
        check("400 v_total", 32'(v_total), 400);
        check("400 pal", 32'(pal_detect), 0);
        check("400 dbl", 32'(dbl_detect), 1);
        frame(400, 4, 3, 22, 1, 1'b1);
        kick();
        check("400 relock", 32'(locked), 1);

        // hsync stuck low while locked: hpos saturates and lock drops on that cycle.
        for (int i = 0; i < 1022; i++) idle();
        check("hpos 1022", 32'(hpos), 1022);
        check("locked before sat", 32'(locked), 1);
        idle();
        check("hpos 1023", 32'(hpos), 1023);
        check("unlock at sat", 32'(locked), 0);
        for (int i = 0; i < 77; i++) idle();
        check("hpos held 1023", 32'(hpos), 1023);
        pix(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        check("h_total saturated", 32'(h_total), 1023);

        // Reset mid-line: immediate clear, first capture after release is partial.
        for (int i = 0; i < 5; i++) idle();
        check("hpos mid-line", 32'(hpos), 5);
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) idle();
        pix(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        check("post-reset first h_total", 32'(h_total), 6);
        check("post-reset first h_active", 32'(h_active), 5);
        run_line(16, 12, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        pix(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        check("post-reset h_total", 32'(h_total), 16);
        check("post-reset h_active", 32'(h_active), 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_meter.md
VIDEO_TIMING_METER -- requirements
Module: video_timing_meter

Interface
REQ-001 LOCK_FRAMES, 2, number of consecutive identical frame measurements required before locked asserts; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ce_pix  input  1  pixel clock enable; sync inputs are sampled only on clk edges where ce_pix=1.
REQ-005 hsync, vsync  input  1 each  active-high sync from the timing generator.
REQ-006 hblank, vblank  input  1 each  active-high blanking flags.
REQ-007 video  input  8  pixel luma.
REQ-008 h_total  output  10  measured pixels per line.
REQ-009 h_active  output  10  measured non-blanked pixels per line.
REQ-010 v_total  output  10  measured lines per frame.
REQ-011 v_active  output  10  measured non-blanked lines per frame.
REQ-012 hpos, vpos  output  10 each  live pixel/line counters since the last hsync/vsync rising edge.
REQ-013 locked  output  1  stable timing detected.
REQ-014 pal_detect, dbl_detect  output  1 each  PAL-rate and scandoubled-rate classification.
REQ-015 frame_pulse  output  1  single-clk pulse per detected frame start.
REQ-016 luma_max  output  8  peak video value in the active area of the last complete frame.

Function
REQ-017 The block SHALL register hsync and vsync on ce_pix cycles; a rise is a ce_pix cycle with input=1 and registered value=0.
REQ-018 hpos SHALL load 0 on an hsync rise, else increment by 1 per ce_pix cycle, saturating at 1023.
REQ-019 On an hsync rise, h_total SHALL capture hpos+1 (10-bit, saturating at 1023) and h_active SHALL capture the count of ce_pix cycles with hblank=0 since the previous rise; the active counter then clears.
REQ-020 vpos SHALL increment by 1 on each hsync rise, saturating at 1023; on a vsync rise it loads 0.
REQ-021 On a vsync rise, v_total SHALL capture vpos+1 if an hsync rise occurs on the same ce_pix cycle, else vpos; v_active SHALL capture the number of hsync rises since the previous vsync rise that sampled vblank=0 (coincident rise included on the same rule as v_total); both counters then clear.
REQ-022 frame_pulse SHALL be 1 for exactly the clk cycle following the ce_pix cycle of a vsync rise; 0 otherwise.
REQ-023 luma_max SHALL capture, on each vsync rise, the maximum video sampled on ce_pix cycles with hblank=0 and vblank=0 since the previous vsync rise; the running maximum then clears to 0.
REQ-024 Lock FSM states: SEARCH, CONFIRM, LOCKED; SEARCH->CONFIRM on a vsync rise (stores h_total/v_total reference, match count=1).
REQ-025 In CONFIRM, each vsync rise with h_total and v_total equal to the reference SHALL increment the match count; reaching LOCK_FRAMES moves to LOCKED; a mismatch reloads the reference with count=1.
REQ-026 In LOCKED, a vsync rise with mismatching totals, or hpos reaching 1023, SHALL return to SEARCH in that cycle; locked=1 only in LOCKED.
REQ-027 pal_detect SHALL be 1 when v_total is 281..399 or >=580; dbl_detect SHALL be 1 when v_total >=400; both combinational from registered v_total.
REQ-028 Simultaneous hsync and vsync rise SHALL be handled in one ce_pix cycle per REQ-019..REQ-021 with no lost or double-counted line.
REQ-029 Sync edges occurring while ce_pix=0 SHALL be ignored until the next ce_pix cycle samples them.

Reset
REQ-030 While reset=1 all counters, captured measurements, luma_max, frame_pulse, locked, registered sync samples SHALL be 0 and the FSM SHALL be SEARCH; pal_detect/dbl_detect therefore 0.
REQ-031 Reset asserted mid-frame SHALL discard partial measurements; the first capture after release requires a fresh hsync/vsync rise.

Verification
REQ-032 NTSC 638x262 frames, ce_pix every other clk, vsync coincident with hsync, vblank 22 lines -> h_total=638, v_total=262, v_active=240, pal_detect=0, dbl_detect=0.
REQ-033 PAL scandoubled 638x624, ce_pix=1 -> v_total=624, pal_detect=1, dbl_detect=1, locked=1 after third vsync rise with LOCK_FRAMES=2.
REQ-034 Locked stream, one frame with 263 lines -> locked=0 at that vsync rise, relocks after LOCK_FRAMES matching frames.
REQ-035 hsync held low 1100 ce_pix cycles while LOCKED -> hpos saturates at 1023, locked=0 that cycle.
REQ-036 Active video ramp peaking 0xC8, 0xFF driven only during blanking -> luma_max=0xC8 after vsync rise.
REQ-037 reset pulsed mid-line -> all outputs 0 immediately, first h_total valid only after second hsync rise.
